// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: owns the 8x4-bit digit buffer, round-robins buffer writes between two requesters, and scans the digits with a blanking gap at the start of each slot.
// Latency: gnt pulses one cycle after req is sampled, and the write commits on that same edge; a committed digit reaches digit_val one cycle later.
// Backpressure: each requester holds req (level) until it sees gnt; the losing requester simply waits, and nothing is queued.
//
// Ports:
//   clk, rst           single clock; synchronous active-high reset
//   req[1:0]           per-requester write request (level)
//   addr0/data0        requester 0 digit address / value
//   addr1/data1        requester 1 digit address / value
//   gnt[1:0]           one-hot one-cycle grant; the buffer write commits on the edge that raises it
//   digit_val[3:0]     registered value of the scanned digit
//   digit_sel[7:0]     registered one-hot digit enable; all zero while blanked
//   blank              registered; 1 while no digit is driven
//
// Optional feature: define SEG_LZB_EN to enable leading-zero blanking of digits 7..1.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int GAP      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [2:0] addr0,
  input  logic [3:0] data0,
  input  logic [2:0] addr1,
  input  logic [3:0] data1,
  output logic [1:0] gnt,
  output logic [3:0] digit_val,
  output logic [7:0] digit_sel,
  output logic       blank
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [2:0]    idx;
  logic [2:0]    idx_nxt;
  logic          wrap;
  logic          favour1;   // 1: requester 1 wins a tie
  logic [1:0]    gnt_nxt;
  logic [3:0]    dbuf [8];
  logic [7:0]    sup;       // per-digit suppression (leading-zero blanking)
  logic          in_gap;
  logic          show;

  // Arbitration: a lone request wins outright; the pointer breaks a tie.
  always_comb begin
    gnt_nxt = req;
    if (req == 2'b11) begin
      gnt_nxt = favour1 ? 2'b10 : 2'b01;
    end
  end

  // Next-state scan position; the outputs are registered from these values so
  // that they line up with the cnt/idx registers.
  always_comb begin
    wrap    = (cnt == CW'(SCAN_DIV - 1));
    cnt_nxt = wrap ? '0 : cnt + CW'(1);
    idx_nxt = wrap ? idx + 3'd1 : idx;
  end

`ifdef SEG_LZB_EN
  logic zero_above;

  // Digit i (i >= 1) is suppressed when it and every digit above it hold zero.
  // This reads the live buffer, so it tracks writes with the same one-cycle
  // lag as digit_val.
  always_comb begin
    zero_above = 1'b1;
    sup        = '0;
    for (int i = 7; i >= 1; i--) begin
      zero_above = zero_above & (dbuf[i] == 4'd0);
      sup[i]     = zero_above;
    end
  end
`else
  assign sup = '0;
`endif

  // A signed int compare keeps GAP = 0 well defined: nothing is ever in the gap.
  assign in_gap = (int'(cnt_nxt) < GAP);
  assign show   = !in_gap && !sup[idx_nxt];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      favour1   <= 1'b0;
      gnt       <= '0;
      digit_sel <= '0;
      blank     <= 1'b1;
      digit_val <= '0;
      for (int i = 0; i < 8; i++) begin
        dbuf[i] <= 4'(i + 1);
      end
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      gnt <= gnt_nxt;
      if (gnt_nxt[0]) begin
        dbuf[addr0] <= data0;
        favour1     <= 1'b1;
      end else if (gnt_nxt[1]) begin
        dbuf[addr1] <= data1;
        favour1     <= 1'b0;
      end
      // This reads the pre-write buffer. A digit written on this edge
      // therefore shows one cycle later.
      digit_val <= dbuf[idx_nxt];
      digit_sel <= show ? (8'd1 << idx_nxt) : 8'd0;
      blank     <= ~show;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: checks seg_scan_ctrl (SCAN_DIV=8, GAP=2) against a cycle-count based reference model.
// The model derives the scan position from the number of edges since reset and keeps its own buffer.
// Directed scenarios pin the model with literal values; a random phase then exercises arbitration and reset.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV = 8;
  localparam int GAP      = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [2:0] addr0;
  logic [3:0] data0;
  logic [2:0] addr1;
  logic [3:0] data1;
  logic [1:0] gnt;
  logic [3:0] digit_val;
  logic [7:0] digit_sel;
  logic       blank;

  int tests = 0;
  int fails = 0;

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr0     (addr0),
    .data0     (data0),
    .addr1     (addr1),
    .data1     (data1),
    .gnt       (gnt),
    .digit_val (digit_val),
    .digit_sel (digit_sel),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_valid = 1'b0;
  int         m_n;          // edges since reset
  bit         m_fav1;       // requester 1 wins the next tie
  logic [3:0] m_buf [8];
  logic [3:0] m_old [8];
  logic [1:0] m_g;
  int         m_cnt;
  int         m_idx;
  bit         m_sup;
  logic [1:0] e_gnt;
  logic [7:0] e_sel;
  logic       e_blank;
  logic [3:0] e_val;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_n     = 0;
      m_fav1  = 1'b0;
      for (int i = 0; i < 8; i++) m_buf[i] = 4'(i + 1);
      e_gnt   = 2'b00;
      e_sel   = 8'h00;
      e_blank = 1'b1;
      e_val   = 4'h0;
    end else if (m_valid) begin
      m_old = m_buf;
      if (req == 2'b11) m_g = m_fav1 ? 2'b10 : 2'b01;
      else              m_g = req;
      if (m_g == 2'b01) begin
        m_buf[addr0] = data0;
        m_fav1       = 1'b1;
      end else if (m_g == 2'b10) begin
        m_buf[addr1] = data1;
        m_fav1       = 1'b0;
      end
      m_n++;
      m_cnt = m_n % SCAN_DIV;
      m_idx = (m_n / SCAN_DIV) % 8;
      m_sup = 1'b0;
`ifdef SEG_LZB_EN
      if (m_idx != 0) begin
        m_sup = 1'b1;
        for (int j = m_idx; j < 8; j++) if (m_old[j] != 4'h0) m_sup = 1'b0;
      end
`endif
      e_gnt = m_g;
      e_val = m_old[m_idx];
      if (m_cnt < GAP || m_sup) begin
        e_sel   = 8'h00;
        e_blank = 1'b1;
      end else begin
        e_sel   = 8'(1 << m_idx);
        e_blank = 1'b0;
      end
    end
    #1;
    if (m_valid) begin
      check("gnt", gnt, e_gnt);
      check("digit_sel", digit_sel, e_sel);
      check("blank", blank, e_blank);
      check("digit_val", digit_val, e_val);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Single-requester write: raise req, observe gnt after one edge, drop req.
  task automatic wr(input int who, input logic [2:0] a, input logic [3:0] d, output logic [1:0] seen);
    if (who == 0) begin
      addr0 = a;
      data0 = d;
      req   = 2'b01;
    end else begin
      addr1 = a;
      data1 = d;
      req   = 2'b10;
    end
    step(1);
    seen = gnt;
    req  = 2'b00;
  endtask

  task automatic wait_sel(input logic [7:0] s, input string name);
    int k = 0;
    while (digit_sel !== s && k < 200) begin
      step(1);
      k++;
    end
    check({name, "_found"}, 32'(digit_sel === s), 32'd1);
  endtask

  logic [1:0] t3_exp [6];
  logic [1:0] seen;
  int         hi;

  initial begin
    rst = 1'b1; req = 2'b00;
    addr0 = '0; data0 = '0; addr1 = '0; data1 = '0;
    step(2);
    check("rst_gnt", gnt, 2'b00);
    check("rst_sel", digit_sel, 8'h00);
    check("rst_blank", blank, 1'b1);
    check("rst_val", digit_val, 4'h0);
    rst = 1'b0;

    // 1: free-running scan
    step(9);                                  // n=9: idx1, cnt1 (gap)
    check("t1_gap_sel", digit_sel, 8'h00);
    check("t1_gap_blank", blank, 1'b1);
    check("t1_gap_val", digit_val, 4'h2);
    step(1);                                  // n=10: idx1, cnt2
    check("t1_sel", digit_sel, 8'h02);
    check("t1_blank", blank, 1'b0);
    step(54);                                 // n=64: wrapped to idx0, cnt0
    check("t1_wrap_sel", digit_sel, 8'h00);
    check("t1_wrap_val", digit_val, 4'h1);
    step(2);                                  // n=66
    check("t1_wrap_sel2", digit_sel, 8'h01);

    // 2: single write
    wr(0, 3'd3, 4'hA, seen);
    check("t2_gnt", seen, 2'b01);
    step(1);
    check("t2_gnt_drop", gnt, 2'b00);
    wait_sel(8'h08, "t2_slot");
    check("t2_val", digit_val, 4'hA);

    // 3: both requesting; the last grant went to 0, so requester 1 leads
    t3_exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    addr0 = 3'd0; data0 = 4'h5; addr1 = 3'd1; data1 = 4'h6;
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t3_gnt", gnt, t3_exp[i]);
    end
    req = 2'b00;
    wait_sel(8'h01, "t3_d0");
    check("t3_d0_val", digit_val, 4'h5);
    wait_sel(8'h02, "t3_d1");
    check("t3_d1_val", digit_val, 4'h6);

    // 4: write digit2 inside its own slot, committing at cnt=4
    wait_sel(8'h00, "t4_gap");
    wait_sel(8'h04, "t4_slot");               // cnt=2
    step(1);                                  // cnt=3
    wr(0, 3'd2, 4'hF, seen);                  // commits on the edge to cnt=4
    check("t4_gnt", seen, 2'b01);
    check("t4_old_val", digit_val, 4'h3);
    check("t4_sel", digit_sel, 8'h04);
    step(1);
    check("t4_new_val", digit_val, 4'hF);
    check("t4_sel2", digit_sel, 8'h04);

    // 5: reset mid-scan with a pending request
    wait_sel(8'h20, "t5_slot");               // idx5, cnt2
    step(4);                                  // cnt6
    rst = 1'b1; addr1 = 3'd7; data1 = 4'h9; req = 2'b10;
    step(1);
    check("t5_gnt", gnt, 2'b00);
    check("t5_sel", digit_sel, 8'h00);
    check("t5_blank", blank, 1'b1);
    check("t5_val", digit_val, 4'h0);
    rst = 1'b0; req = 2'b00;
    wait_sel(8'h08, "t5_d3");
    check("t5_d3_val", digit_val, 4'h4);
    wait_sel(8'h80, "t5_d7");
    check("t5_d7_val", digit_val, 4'h8);

    // 6: leading zeros (7..2 = 0, digit1 = 4, digit0 = 0)
    for (int a = 7; a >= 2; a--) begin
      wr(1, 3'(a), 4'h0, seen);
      check("t6_gnt", seen, 2'b10);
    end
    wr(0, 3'd1, 4'h4, seen);
    check("t6_gnt1", seen, 2'b01);
    wr(1, 3'd0, 4'h0, seen);
    check("t6_gnt0", seen, 2'b10);
    step(2);
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if ((digit_sel & 8'hFC) != 8'h00) hi++;
    end
`ifdef SEG_LZB_EN
    check("t6_hi_cycles", hi, 0);
`else
    check("t6_hi_cycles", hi, 36);
`endif
    wait_sel(8'h02, "t6_d1");
    check("t6_d1_val", digit_val, 4'h4);
    wait_sel(8'h01, "t6_d0");
    check("t6_d0_val", digit_val, 4'h0);

    // random phase, compared cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      req   = 2'($urandom_range(0, 3));
      addr0 = 3'($urandom_range(0, 7));
      addr1 = 3'($urandom_range(0, 7));
      data0 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      data1 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(1);
    end
    rst = 1'b0; req = 2'b00;
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
